sha256_round_seq: RTL

SHA256_ROUND_SEQ -- requirements
Module: sha256_round_seq

---
 rtl/sha256_round_seq_if.sv | 28 ++
 rtl/sha256_round_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_seq_if.sv
// Register bus and datapath strobe bundle for sha256_round_seq.
// The signal names follow the block's pin list; DONE_IRQ is driven only when SHA256_DONE_IRQ_EN is defined.
interface sha256_round_seq_if;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;
  logic        DP_LOAD;
  logic        DP_RND;
  logic        DP_FINAL;
  logic [5:0]  DP_IDX;
  logic [31:0] DP_W;
  logic [31:0] DP_K;
  logic        DONE_IRQ;

  modport master (
    output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    input  RDATA, DP_LOAD, DP_RND, DP_FINAL, DP_IDX, DP_W, DP_K, DONE_IRQ
  );

  modport slave (
    input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    output RDATA, DP_LOAD, DP_RND, DP_FINAL, DP_IDX, DP_W, DP_K, DONE_IRQ
  );
endinterface

// File: rtl/sha256_round_seq.sv
// SHA-256 round sequencer: W push buffer, message schedule, K ROM and round strobes.
// Optional macro SHA256_DONE_IRQ_EN drives DONE_IRQ from the DONE status bit.
module sha256_round_seq (
  input  logic                ACLK,
  input  logic                ARESET,
  sha256_round_seq_if.slave   bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;
  localparam int unsigned IW = 6;
  localparam int unsigned CW = 5;
  localparam logic [15:0] ADDR_STAT = 16'h4040;
  localparam logic [15:0] ADDR_W    = 16'h4044;
  localparam logic [15:0] ADDR_K    = 16'h4048;

  localparam logic [DW-1:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL} state_e;

  function automatic logic [DW-1:0] sig0(input logic [DW-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [DW-1:0] sig1(input logic [DW-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   buf_q [NW];
  logic [DW-1:0]   buf_d [NW];
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            dp_load_q, dp_load_d;
  logic            dp_rnd_q, dp_rnd_d;
  logic            dp_final_q, dp_final_d;
  logic [DW-1:0]   w_q, w_d;
  logic [DW-1:0]   k_q, k_d;

  logic            busy;
  logic            wr_stat;
  logic            start_wr;
  logic            start_go;
  logic            start_err;
  logic            push_ok;
  logic [DW-1:0]   sched_w;
  logic [3:0]      sidx;

  // Bus decode
  always_comb begin
    busy      = (state_q != ST_IDLE);
    wr_stat   = bus.WREN && (bus.WRADDR == ADDR_STAT) && bus.BYTEEN[0];
    start_wr  = wr_stat && bus.WDATA[4];
    start_go  = start_wr && !busy && (cnt_q == CW'(NW));
    start_err = start_wr && !busy && (cnt_q != CW'(NW));
    push_ok   = bus.WREN && (bus.WRADDR == ADDR_W) && (bus.BYTEEN == 4'hF) &&
                !busy && (cnt_q != CW'(NW));
  end

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ROUND;
      ST_ROUND: if (idx_q == IW'(63)) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q
  always_comb begin
    dp_load_d  = 1'b0;
    dp_rnd_d   = 1'b0;
    dp_final_d = 1'b0;
    case (state_d)
      ST_LOAD:  dp_load_d  = 1'b1;
      ST_ROUND: dp_rnd_d   = 1'b1;
      ST_FINAL: dp_final_d = 1'b1;
      default:  ;
    endcase
  end

  // Schedule word for the next round index; the entry written back this cycle is never one of its taps
  always_comb begin
    idx_d   = ((state_q == ST_ROUND) && (state_d == ST_ROUND)) ? IW'(idx_q + IW'(1)) : '0;
    sidx    = idx_d[3:0];
    sched_w = '0;
    if (idx_d < IW'(NW)) begin
      sched_w = buf_q[sidx];
    end else begin
      sched_w = sig1(buf_q[4'(sidx - 4'd2)]) + buf_q[4'(sidx - 4'd7)] +
                sig0(buf_q[4'(sidx - 4'd15)]) + buf_q[sidx];
    end
    w_d = (state_d == ST_ROUND) ? sched_w : '0;
    k_d = (state_d == ST_ROUND) ? K_ROM[idx_d] : '0;
  end

  // Buffer, counters, status bits and read data
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    if (push_ok) begin
      buf_d[cnt_q[3:0]] = bus.WDATA;
      cnt_d             = CW'(cnt_q + CW'(1));
    end
    if (start_go) cnt_d = '0;
    if ((state_q == ST_ROUND) && (idx_q >= IW'(NW))) buf_d[idx_q[3:0]] = w_q;

    // Set has priority over a same-cycle W1C
    if (wr_stat && bus.WDATA[0]) done_d = 1'b0;
    if (state_q == ST_FINAL)     done_d = 1'b1;
    if (wr_stat && bus.WDATA[2]) err_d  = 1'b0;
    if (start_err)               err_d  = 1'b1;

    if (bus.RDEN) begin
      case (bus.RDADDR)
        ADDR_STAT: rdata_d = {27'd0, 2'b00, err_q, busy, done_q};
        ADDR_W:    rdata_d = {27'd0, cnt_q};
        ADDR_K:    rdata_d = K_ROM[idx_q];
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '{default: '0};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      dp_load_q  <= 1'b0;
      dp_rnd_q   <= 1'b0;
      dp_final_q <= 1'b0;
      w_q        <= '0;
      k_q        <= '0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dp_load_q  <= dp_load_d;
      dp_rnd_q   <= dp_rnd_d;
      dp_final_q <= dp_final_d;
      w_q        <= w_d;
      k_q        <= k_d;
    end
  end

  assign bus.RDATA    = rdata_q;
  assign bus.DP_LOAD  = dp_load_q;
  assign bus.DP_RND   = dp_rnd_q;
  assign bus.DP_FINAL = dp_final_q;
  assign bus.DP_IDX   = idx_q;
  assign bus.DP_W     = w_q;
  assign bus.DP_K     = k_q;

`ifdef SHA256_DONE_IRQ_EN
  assign bus.DONE_IRQ = done_q;
`else
  assign bus.DONE_IRQ = 1'b0;
`endif

endmodule
